// File: rtl/calc1_pkg.sv
// calc1_pkg: shared command/response codes, latency-counter width and FSM
// state encoding for the calc1 single-port responder.
package calc1_pkg;

    // Command codes as seen on req_cmd
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    // Response codes driven on out_resp (code 3 is never produced)
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    // Latency counter width; EXEC_LAT is limited to 1..15
    localparam int CNT_W = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// calc1_alu: combinational execute stage for one calc1 port.
// Unsigned add with carry detection, subtract with underflow detection and,
// when CALC1_SHIFT_EN is defined, logical left/right shifts by the low
// $clog2(DW) bits of op2. Without CALC1_SHIFT_EN no shifter is built and the
// shift commands fall through to the invalid-command response.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    output logic [1:0]    resp,
    output logic [DW-1:0] result
);

    // Extra bit holds the carry-out of the addition
    logic [DW:0] sum;
    assign sum = {1'b0, op1} + {1'b0, op2};

`ifdef CALC1_SHIFT_EN
    localparam int SHW = $clog2(DW);
    logic [SHW-1:0] shamt;
    assign shamt = op2[SHW-1:0];
`endif

    // Decode the command; anything not recognised is an error with zero data
    always_comb begin
        resp   = RESP_ERR;
        result = '0;
        case (cmd)
            CMD_ADD: begin
                if (sum[DW]) begin
                    resp   = RESP_ERR;
                    result = '0;
                end else begin
                    resp   = RESP_OK;
                    result = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    resp   = RESP_ERR;
                    result = '0;
                end else begin
                    resp   = RESP_OK;
                    result = op1 - op2;
                end
            end
`ifdef CALC1_SHIFT_EN
            CMD_SHL: begin
                resp   = RESP_OK;
                result = op1 << shamt;
            end
            CMD_SHR: begin
                resp   = RESP_OK;
                result = op1 >> shamt;
            end
`endif
            default: begin
                resp   = RESP_ERR;
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1_port_responder: calculator side of one calc1 request/response port.
// Captures cmd+op1, then op2 on the following cycle, waits EXEC_LAT cycles
// from the op2 edge and presents a one-cycle response. Commands arriving
// while busy are dropped. Optional shifter enabled by CALC1_SHIFT_EN.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int DW       = 32,
    parameter int EXEC_LAT = 2
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [3:0]    req_cmd,
    input  logic [DW-1:0] req_data,
    output logic [1:0]    out_resp,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    // Counter starts at EXEC_LAT-1 on the op2 edge so the result lands
    // exactly EXEC_LAT edges later.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_LAT - 1);

    state_t           state_q;
    logic [3:0]       cmd_q;
    logic [DW-1:0]    op1_q;
    logic [DW-1:0]    op2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       resp_q;
    logic [DW-1:0]    data_q;
    logic             busy_q;

    // Next values for the output registers, produced by the execute stage
    logic [1:0]       resp_d;
    logic [DW-1:0]    data_d;

    calc1_alu #(
        .DW (DW)
    ) u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .resp   (resp_d),
        .result (data_d)
    );

    // Request FSM with registered outputs; reset aborts any request in flight
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_cmd != CMD_NOP) begin
                        cmd_q   <= req_cmd;
                        op1_q   <= req_data;
                        busy_q  <= 1'b1;
                        state_q <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    // Operand 2 is taken regardless of req_cmd, even for invalid commands
                    op2_q   <= req_data;
                    cnt_q   <= CNT_INIT;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        resp_q  <= resp_d;
                        data_q  <= (resp_d == RESP_OK) ? data_d : '0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_q  <= RESP_NONE;
                    data_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// tb_calc1_port_responder: scoreboard bench for calc1_port_responder.
// Expected responses (code, data, due cycle) are queued when a command is
// issued and popped by a negedge monitor whenever out_resp is non-zero.
// Shift expectations follow the CALC1_SHIFT_EN build option.
module tb_calc1_port_responder;

    localparam int DW       = 32;
    localparam int EXEC_LAT = 2;

    logic          c_clk;
    logic          reset;
    logic [3:0]    req_cmd;
    logic [DW-1:0] req_data;
    logic [1:0]    out_resp;
    logic [DW-1:0] out_data;
    logic          busy;

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    calc1_port_responder #(
        .DW       (DW),
        .EXEC_LAT (EXEC_LAT)
    ) dut (
        .c_clk    (c_clk),
        .reset    (reset),
        .req_cmd  (req_cmd),
        .req_data (req_data),
        .out_resp (out_resp),
        .out_data (out_data),
        .busy     (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop the scoreboard for every response cycle and check code, data, timing
    always @(negedge c_clk) begin
        if (!reset && out_resp != 2'd0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 32'(out_resp), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("resp_code", 32'(out_resp), 32'(mon_e.resp));
                check_eq("resp_data", out_data, mon_e.data);
                check_eq("resp_cycle", 32'(cyc), 32'(mon_e.due));
                check_eq("busy_in_resp", 32'(busy), 32'd1);
            end
        end
    end

    // Wait at a negedge until the port is idle, with a cycle budget
    task automatic wait_idle();
        int budget = 50;
        @(negedge c_clk);
        while (busy && budget > 0) begin
            @(negedge c_clk);
            budget--;
        end
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                         input logic [1:0] er, input logic [DW-1:0] ed);
        exp_t e;
        wait_idle();
        req_cmd  = cmd;
        req_data = op1;
        @(posedge c_clk);
        #1;
        e.resp = er;
        e.data = ed;
        e.due  = cyc + EXEC_LAT + 1;
        sb.push_back(e);
        @(negedge c_clk);
        req_cmd  = 4'd0;
        req_data = op2;
        @(negedge c_clk);
        req_data = '0;
    endtask

    initial begin
        exp_t e;
        logic [1:0] shift_resp;
        logic [DW-1:0] shl_data, shr_data, sh0_data;
`ifdef CALC1_SHIFT_EN
        shift_resp = 2'd1;
        shl_data   = 32'h8000_0000;
        shr_data   = 32'h0000_0001;
        sh0_data   = 32'h1234_5678;
`else
        shift_resp = 2'd2;
        shl_data   = '0;
        shr_data   = '0;
        sh0_data   = '0;
`endif
        reset    = 1'b1;
        req_cmd  = 4'd0;
        req_data = '0;

        // Reset held for 4 cycles, outputs quiet throughout and after
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            check_eq("rst_resp", 32'(out_resp), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge c_clk);
            check_eq("post_rst_resp", 32'(out_resp), 32'd0);
            check_eq("post_rst_data", out_data, 32'd0);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end

        // Basic add and arithmetic boundaries
        issue(4'd1, 32'h1,         32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
        issue(4'd1, 32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0);
        issue(4'd1, 32'hFFFF_FFFF, 32'h0,         2'd1, 32'hFFFF_FFFF);
        issue(4'd2, 32'h1,         32'hF,         2'd2, 32'h0);
        issue(4'd2, 32'h5,         32'h5,         2'd1, 32'h0);
        issue(4'd2, 32'h10,        32'h3,         2'd1, 32'hD);

        // Invalid commands and shifts
        issue(4'd3,  32'h1, 32'h1, 2'd2, 32'h0);
        issue(4'd4,  32'h1, 32'h1, 2'd2, 32'h0);
        issue(4'd15, 32'h7, 32'h1, 2'd2, 32'h0);
        issue(4'd5,  32'h1, 32'd31, shift_resp, shl_data);
        issue(4'd6,  32'h8000_0000, 32'hFFFF_FFFF, shift_resp, shr_data);
        issue(4'd5,  32'h1234_5678, 32'h0, shift_resp, sh0_data);

        // Walking-one add with zero
        for (int k = 0; k < 32; k++) begin
            logic [DW-1:0] v;
            v = 32'h1 << k;
            issue(4'd1, v, 32'h0, 2'd1, v);
        end

        // Commands while busy are dropped
        wait_idle();
        req_cmd  = 4'd1;
        req_data = 32'd10;
        @(posedge c_clk);
        #1;
        e.resp = 2'd1;
        e.data = 32'd30;
        e.due  = cyc + EXEC_LAT + 1;
        sb.push_back(e);
        @(negedge c_clk);
        req_data = 32'd20;               // op2; req_cmd stays 1 and must be ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge c_clk);
            check_eq("busy_drop", 32'(busy), 32'd1);
            req_cmd  = 4'd1;
            req_data = 32'hDEAD_0000 + 32'(i);
        end
        @(negedge c_clk);
        req_cmd  = 4'd0;
        req_data = '0;
        wait_idle();
        repeat (4) @(negedge c_clk);
        check_eq("drop_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during EXEC aborts the request silently
        wait_idle();
        req_cmd  = 4'd1;
        req_data = 32'd7;
        @(negedge c_clk);
        req_cmd  = 4'd0;
        req_data = 32'd8;
        @(negedge c_clk);
        req_data = '0;
        reset    = 1'b1;
        @(negedge c_clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (6) begin
            @(negedge c_clk);
            check_eq("abort_quiet", 32'(out_resp), 32'd0);
        end
        issue(4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

        wait_idle();
        repeat (4) @(negedge c_clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
